// File: rtl/led_seq_ctrl.sv
// LED pattern sequencer behind the LED IP's AXI4-Lite slave: register decode, mode FSM, step prescaler.
// Optional PWM brightness stage is enabled by defining LED_SEQ_PWM_EN.
module led_seq_ctrl #(
    parameter int unsigned LED_WIDTH = 8,
    parameter int unsigned PRESC_W   = 24
) (
    input  logic                 S_AXI_ACLK,
    input  logic                 S_AXI_ARESETN,
    input  logic                 slv_reg_wren,
    input  logic [2:0]           axi_awaddr,
    input  logic [31:0]          S_AXI_WDATA,
    output logic [LED_WIDTH-1:0] LED,
    output logic                 step_tick,
    output logic                 busy
);

    localparam int unsigned MSB = LED_WIDTH - 1;

    typedef enum logic [2:0] {
        ST_OFF    = 3'd0,
        ST_STATIC = 3'd1,
        ST_BLINK  = 3'd2,
        ST_CHASE  = 3'd3,
        ST_BOUNCE = 3'd4
    } state_e;

    state_e               state_q, state_d;
    logic                 en_q, en_d;
    logic [1:0]           mode_q, mode_d;
    logic [LED_WIDTH-1:0] pattern_q, pattern_d;
    logic [PRESC_W-1:0]   period_q, period_d;
    logic [PRESC_W-1:0]   presc_q;
    logic [LED_WIDTH-1:0] work_q, work_init, work_step;
    logic                 phase_q, phase_step;
    logic                 dir_q, dir_step;
    logic [LED_WIDTH-1:0] led_q, pattern_out, led_mask;
    logic                 step_tick_q;
    logic                 wr_ctrl, wr_pat, wr_per, restart;
    logic                 unused_wdata;

    assign unused_wdata = ^S_AXI_WDATA;

    // Register write decode; any write to indices 0..2 restarts the animation
    always_comb begin
        wr_ctrl   = slv_reg_wren && (axi_awaddr == 3'd0);
        wr_pat    = slv_reg_wren && (axi_awaddr == 3'd1);
        wr_per    = slv_reg_wren && (axi_awaddr == 3'd2);
        restart   = wr_ctrl || wr_pat || wr_per;
        en_d      = wr_ctrl ? S_AXI_WDATA[0]   : en_q;
        mode_d    = wr_ctrl ? S_AXI_WDATA[2:1] : mode_q;
        pattern_d = wr_pat  ? S_AXI_WDATA[LED_WIDTH-1:0] : pattern_q;
        period_d  = wr_per  ? S_AXI_WDATA[PRESC_W-1:0]   : period_q;
    end

    // Target state and work seed that a restart loads
    always_comb begin
        state_d = ST_OFF;
        if (en_d) begin
            unique case (mode_d)
                2'd0:    state_d = ST_STATIC;
                2'd1:    state_d = ST_BLINK;
                2'd2:    state_d = ST_CHASE;
                default: state_d = ST_BOUNCE;
            endcase
        end
        if (mode_d == 2'd3) begin
            work_init = pattern_d & (LED_WIDTH'(~pattern_d) + LED_WIDTH'(1));
        end else begin
            work_init = pattern_d;
        end
    end

    // Animation update applied on each step
    always_comb begin
        work_step  = work_q;
        phase_step = phase_q;
        dir_step   = dir_q;
        unique case (state_q)
            ST_BLINK: phase_step = ~phase_q;
            ST_CHASE: work_step = {work_q[MSB-1:0], work_q[MSB]};
            ST_BOUNCE: begin
                if (!dir_q) begin
                    if (work_q[MSB]) begin
                        dir_step  = 1'b1;
                        work_step = work_q >> 1;
                    end else begin
                        work_step = work_q << 1;
                    end
                end else begin
                    if (work_q[0]) begin
                        dir_step  = 1'b0;
                        work_step = work_q << 1;
                    end else begin
                        work_step = work_q >> 1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        pattern_out = work_q;
        unique case (state_q)
            ST_OFF:   pattern_out = '0;
            ST_BLINK: pattern_out = phase_q ? work_q : '0;
            default:  pattern_out = work_q;
        endcase
    end

`ifdef LED_SEQ_PWM_EN
    logic [7:0] bright_q;
    logic [7:0] pwm_cnt_q;

    // Brightness gate: LEDs lit while the free-running counter is below BRIGHT
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            bright_q  <= 8'hFF;
            pwm_cnt_q <= 8'd0;
        end else begin
            pwm_cnt_q <= pwm_cnt_q + 8'd1;
            if (slv_reg_wren && (axi_awaddr == 3'd3)) begin
                bright_q <= S_AXI_WDATA[7:0];
            end
        end
    end

    assign led_mask = {LED_WIDTH{pwm_cnt_q < bright_q}};
`else
    assign led_mask = '1;
`endif

    // Mode FSM, prescaler and animation registers
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            state_q     <= ST_OFF;
            en_q        <= 1'b0;
            mode_q      <= 2'd0;
            pattern_q   <= '0;
            period_q    <= '0;
            presc_q     <= '0;
            work_q      <= '0;
            phase_q     <= 1'b1;
            dir_q       <= 1'b0;
            led_q       <= '0;
            step_tick_q <= 1'b0;
        end else begin
            en_q      <= en_d;
            mode_q    <= mode_d;
            pattern_q <= pattern_d;
            period_q  <= period_d;
            led_q     <= pattern_out & led_mask;
            if (restart) begin
                state_q     <= state_d;
                presc_q     <= period_d;
                work_q      <= work_init;
                phase_q     <= 1'b1;
                dir_q       <= 1'b0;
                step_tick_q <= 1'b0;
            end else if (state_q == ST_OFF) begin
                presc_q     <= period_q;
                step_tick_q <= 1'b0;
            end else begin
                if (presc_q == '0) begin
                    presc_q     <= period_q;
                    step_tick_q <= 1'b1;
                end else begin
                    presc_q     <= presc_q - PRESC_W'(1);
                    step_tick_q <= 1'b0;
                end
                if (step_tick_q) begin
                    work_q  <= work_step;
                    phase_q <= phase_step;
                    dir_q   <= dir_step;
                end
            end
        end
    end

    assign LED       = led_q;
    assign step_tick = step_tick_q;
    assign busy      = en_q && (mode_q != 2'd0);

endmodule
